// File: rtl/qe_bus_master.sv
// qe_bus_master: 68008-style QL expansion-bus cycle initiator.
// Turns a one-clock read/write request into an asl/dsl strobed bus cycle,
// waits for the responder's dtackl and hands back read data.
// Optional feature macro: QE_BUS_MASTER_TIMEOUT_EN (DS-wait abort path).
//
// Handshake: req/wr/req_addr/req_sp/wdata are sampled on the clock edge where
// req=1 and busy=0 (IDLE); req at any other time is dropped, nothing queues.
// Every accepted request produces exactly one one-clock done pulse (timeout
// marks an aborted cycle), unless rst intervenes, in which case no done follows.
module qe_bus_master #(
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       wr,
    input  logic [9:0] req_addr,
    input  logic [3:0] req_sp,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [9:0] address,
    output logic [3:0] sp,
    output logic       asl,
    output logic       dsl,
    output logic       rdwl,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [7:0] db_in,
    input  logic       dtackl,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        AS       = 3'd2,
        DS       = 3'd3,
        TERM     = 3'd4,
        WAIT_NEG = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] setup_cnt;
    logic       wr_q;
    logic       dtack_m;
    logic       dtack_s;
    logic       accept;
    logic       to_hit;

    // next-cycle values of the registered outputs
    logic       busy_nx;
    logic       done_nx;
    logic       asl_nx;
    logic       dsl_nx;
    logic       rdwl_nx;
    logic       db_oe_nx;
    logic [9:0] address_nx;
    logic [3:0] sp_nx;
    logic [7:0] db_out_nx;
    logic [7:0] rdata_nx;

    assign accept    = (state == IDLE) && req;
    assign state_dbg = state;

`ifdef QE_BUS_MASTER_TIMEOUT_EN
    logic [7:0] to_cnt;

    // DS wait counter: zero outside DS, counts elapsed DS clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              to_cnt <= 8'd0;
        else if (state != DS) to_cnt <= 8'd0;
        else                  to_cnt <= to_cnt + 8'd1;
    end

    // true on the DS clock whose edge is the TIMEOUT_CYCLES-th one
    assign to_hit = (state == DS) && (to_cnt == 8'(TIMEOUT_CYCLES - 1));

    // abort flag, raised with done when DS ends without an acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout <= 1'b0;
        else     timeout <= (state == DS) && dtack_s && to_hit;
    end
`else
    assign to_hit  = 1'b0;
    // constant 0 for every legal TIMEOUT_CYCLES; DS simply waits for dtack
    assign timeout = (TIMEOUT_CYCLES < 1);
`endif

    // state register, setup counter, direction latch and dtackl synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            setup_cnt <= 4'd0;
            wr_q      <= 1'b0;
            dtack_m   <= 1'b1;
            dtack_s   <= 1'b1;
        end else begin
            state     <= state_nx;
            setup_cnt <= (state == SETUP) ? setup_cnt + 4'd1 : 4'd0;
            if (accept) wr_q <= wr;
            dtack_m   <= dtackl;
            dtack_s   <= dtack_m;
        end
    end

    // next-state decode; an acknowledge wins over a same-edge timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (req) state_nx = SETUP;
            SETUP:    if (setup_cnt == 4'(SETUP_CYCLES - 1)) state_nx = AS;
            AS:       state_nx = DS;
            DS: begin
                if (!dtack_s)   state_nx = TERM;
                else if (to_hit) state_nx = TERM;
            end
            TERM:     state_nx = timeout ? IDLE : WAIT_NEG;
            WAIT_NEG: if (dtack_s) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // output decode from the state being entered, so outputs track state exactly
    always_comb begin
        busy_nx    = (state_nx != IDLE);
        done_nx    = (state_nx == TERM);
        asl_nx     = !((state_nx == AS) || (state_nx == DS));
        dsl_nx     = (state_nx != DS);
        address_nx = accept ? req_addr : address;
        sp_nx      = accept ? req_sp   : sp;
        db_out_nx  = (accept && wr) ? wdata : db_out;
        rdata_nx   = rdata;
        if (state_nx == IDLE) rdwl_nx = 1'b1;
        else if (accept)      rdwl_nx = ~wr;
        else                  rdwl_nx = rdwl;
        db_oe_nx = 1'b0;
        if (state_nx inside {SETUP, AS, DS, TERM})
            db_oe_nx = accept ? wr : wr_q;
        if ((state == DS) && !dtack_s && !wr_q)
            rdata_nx = db_in;
    end

    // output registers; reset forces strobes and rdwl high, db_oe low at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            asl     <= 1'b1;
            dsl     <= 1'b1;
            rdwl    <= 1'b1;
            db_oe   <= 1'b0;
            address <= 10'd0;
            sp      <= 4'd0;
            db_out  <= 8'd0;
            rdata   <= 8'd0;
        end else begin
            busy    <= busy_nx;
            done    <= done_nx;
            asl     <= asl_nx;
            dsl     <= dsl_nx;
            rdwl    <= rdwl_nx;
            db_oe   <= db_oe_nx;
            address <= address_nx;
            sp      <= sp_nx;
            db_out  <= db_out_nx;
            rdata   <= rdata_nx;
        end
    end

endmodule
